apb_regbank: RTL and testbench

APB_REGBANK -- requirements
Module: apb_regbank

---
 rtl/apb_regbank.sv | 94 +++++++++
 tb/tb_apb_regbank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
// APB register bank: ID register at index 0, read/write registers above it, optional wait states.
// Define APB_REGBANK_PROT_EN to add PPROT and reject unprivileged accesses.
module apb_regbank #(
   parameter int          DATA_W      = 32,
   parameter int          ADDR_W      = 12,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic              PCLK,
   input  logic              PRESET,
`ifdef APB_REGBANK_PROT_EN
   input  logic [2:0]        PPROT,
`endif
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W/8-1:0] PSTRB,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int                NB = DATA_W / 8;
   localparam int                IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [3:0]        WS = 4'(WAIT_STATES);
   localparam logic [DATA_W-1:0] ID = DATA_W'(ID_VALUE);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state, nxt;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [ADDR_W-3:0] idx;
   logic [IW-1:0]     ridx;
   logic              priv, err, wr_ok;

`ifdef APB_REGBANK_PROT_EN
   logic unused_prot;
   assign unused_prot = ^PPROT[2:1];
   assign priv        = PPROT[0];
`else
   assign priv = 1'b1;
`endif

   assign idx  = PADDR[ADDR_W-1:2];
   assign ridx = idx[IW-1:0];

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (PSEL && !PENABLE) nxt = SETUP;
         SETUP:   nxt = PSEL ? ACCESS : IDLE;
         ACCESS:  if (!PSEL || PREADY) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Counter is zero except while an access stays in ACCESS, so SETUP entry always sees 0.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) cnt <= 4'd0;
      else        cnt <= (state == ACCESS && nxt == ACCESS) ? cnt + 4'd1 : 4'd0;
   end

   // Gating on PSEL keeps a dropped select from completing (and writing) on the final cycle.
   assign PREADY  = (state == ACCESS) && PSEL && (cnt == WS);
   assign err     = (PADDR[1:0] != 2'b00) || (32'(idx) >= NUM_REGS) ||
                    (PWRITE && idx == '0) || !priv;
   assign PSLVERR = PREADY && err;
   assign wr_ok   = PREADY && PWRITE && !err;

   always_comb begin
      PRDATA = '0;
      if (PREADY && !PWRITE && !err)
         PRDATA = (idx == '0) ? ID : regs[ridx];
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (wr_ok) begin
         for (int b = 0; b < NB; b++)
            if (PSTRB[b]) regs[ridx][8*b +: 8] <= PWDATA[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_apb_regbank.sv
// Directed bench for apb_regbank: three instances with 0, 3 and 2 wait states on separate buses.
module tb_apb_regbank;

   localparam logic [31:0] ID = 32'hA9B0_0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int  total = 0;
   int  bad   = 0;
   time t_done;

   logic        psel[3], penable[3], pwrite[3];
   logic [11:0] paddr[3];
   logic [31:0] pwdata[3];
   logic [3:0]  pstrb[3];
   logic [2:0]  pprot[3];
   logic [31:0] prdata[3];
   logic        pready[3], pslverr[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_regbank #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
         .PCLK(clk), .PRESET(rst),
`ifdef APB_REGBANK_PROT_EN
         .PPROT(pprot[g]),
`endif
         .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
         .PADDR(paddr[g]), .PWDATA(pwdata[g]), .PSTRB(pstrb[g]),
         .PRDATA(prdata[g]), .PREADY(pready[g]), .PSLVERR(pslverr[g])
      );
   end

   // One APB transfer; waits counts PENABLE cycles with PREADY low, leak flags nonzero outputs before PREADY.
   task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input bit b2b, output logic [31:0] rd, output logic er,
                       output int waits, output bit leak);
      bit done = 0;
      rd = '0; er = 1'b0; waits = 0; leak = 0;
      if (!b2b) begin @(posedge clk); #1; end
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
      paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
      @(negedge clk);
      if (pready[d] || prdata[d] != 0 || pslverr[d]) leak = 1;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (pready[d]) begin
            rd = prdata[d]; er = pslverr[d]; done = 1; t_done = $time;
         end else begin
            waits++;
            if (prdata[d] != 0 || pslverr[d]) leak = 1;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL timeout dut%0d addr=%h got=no PREADY need=PREADY within 40 cycles", d, a);
      end
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er; int w; bit lk;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         total++;
         if ({pready[d], pslverr[d], prdata[d]} !== 34'b0) begin
            bad++;
            $display("FAIL reset_out dut%0d got=%b/%b/%h need=0/0/0", d, pready[d], pslverr[d], prdata[d]);
         end
      end
      @(posedge clk); #1; rst = 1'b0;
      xfer(0, 1'b0, 12'h004, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         bad++; $display("FAIL reset_reg got=%h/%b need=00000000/0", rd, er);
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd; logic er; int w; bit lk;
      xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b0 || w != 1) begin
         bad++; $display("FAIL basic_wr got=err%b waits%0d need=err0 waits1", er, w);
      end
      xfer(0, 1'b0, 12'h004, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || w != 1 || lk) begin
         bad++; $display("FAIL basic_rd got=%h err%b waits%0d leak%0d need=deadbeef err0 waits1 leak0", rd, er, w, lk);
      end
   endtask

   task automatic test_strobe();
      logic [31:0] rd; logic er; int w; bit lk;
      xfer(0, 1'b1, 12'h008, 32'h11223344, 4'b0101, 0, rd, er, w, lk);
      xfer(0, 1'b0, 12'h008, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h00220044) begin bad++; $display("FAIL strb_0101 got=%h need=00220044", rd); end
      xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'b0000, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b0) begin bad++; $display("FAIL strb_zero_err got=%b need=0", er); end
      xfer(0, 1'b0, 12'h008, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h00220044) begin bad++; $display("FAIL strb_zero got=%h need=00220044", rd); end
      xfer(0, 1'b1, 12'h008, 32'hABCDEF01, 4'b1000, 0, rd, er, w, lk);
      xfer(0, 1'b0, 12'h008, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'hAB220044) begin bad++; $display("FAIL strb_1000 got=%h need=ab220044", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int w; bit lk;
      xfer(0, 1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_wr_id got=%b/%h need=1/0", er, rd); end
      xfer(0, 1'b0, 12'h040, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_rd_range got=%b/%h need=1/0", er, rd); end
      xfer(0, 1'b1, 12'h006, 32'h12345678, 4'hF, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b1) begin bad++; $display("FAIL err_wr_misalign got=%b need=1", er); end
      xfer(0, 1'b0, 12'h006, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_rd_misalign got=%b/%h need=1/0", er, rd); end
      xfer(0, 1'b0, 12'h004, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL err_no_update got=%h/%b need=deadbeef/0", rd, er); end
      xfer(0, 1'b0, 12'h000, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== ID || er !== 1'b0) begin bad++; $display("FAIL err_id_kept got=%h/%b need=a9b00001/0", rd, er); end
      xfer(0, 1'b1, 12'h03C, 32'h12345678, 4'hF, 0, rd, er, w, lk);
      xfer(0, 1'b0, 12'h03C, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h12345678 || er !== 1'b0) begin bad++; $display("FAIL last_reg got=%h/%b need=12345678/0", rd, er); end
   endtask

   task automatic test_wait();
      logic [31:0] rd; logic er; int w; bit lk;
      xfer(1, 1'b0, 12'h000, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== ID || er !== 1'b0 || w != 4 || lk) begin
         bad++; $display("FAIL wait3_id got=%h err%b waits%0d leak%0d need=a9b00001 err0 waits4 leak0", rd, er, w, lk);
      end
      xfer(1, 1'b1, 12'h010, 32'hCAFEF00D, 4'hF, 0, rd, er, w, lk);
      xfer(1, 1'b0, 12'h010, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'hCAFEF00D || w != 4) begin
         bad++; $display("FAIL wait3_rw got=%h waits%0d need=cafef00d waits4", rd, w);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int w; bit lk; time t1;
      xfer(0, 1'b1, 12'h020, 32'h0000A5A5, 4'hF, 0, rd, er, w, lk);
      t1 = t_done;
      xfer(0, 1'b0, 12'h020, 0, 4'h0, 1, rd, er, w, lk);
      total++;
      if (rd !== 32'h0000A5A5 || (t_done - t1) != 30) begin
         bad++; $display("FAIL b2b got=%h dt=%0t need=0000a5a5 dt=30", rd, t_done - t1);
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er; int w; bit lk; bit seen;
      seen = 0;
      @(posedge clk); #1;
      psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 12'h024; pwdata[0] = 32'h77; pstrb[0] = 4'hF;
      @(posedge clk); #1; psel[0] = 0;
      @(negedge clk); if (pready[0] || pslverr[0]) seen = 1;
      @(posedge clk); #1;
      @(negedge clk); if (pready[0] || pslverr[0]) seen = 1;
      xfer(0, 1'b0, 12'h024, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h0 || seen) begin bad++; $display("FAIL abort_setup got=%h flag%0d need=0 flag0", rd, seen); end
      seen = 0;
      @(posedge clk); #1;
      psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 12'h028; pwdata[1] = 32'h99; pstrb[1] = 4'hF;
      @(posedge clk); #1; penable[1] = 1;
      @(posedge clk); #1;
      @(posedge clk); #1; psel[1] = 0; penable[1] = 0;
      @(negedge clk); if (pready[1] || pslverr[1]) seen = 1;
      xfer(1, 1'b0, 12'h028, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h0 || seen || w != 4) begin
         bad++; $display("FAIL abort_access got=%h flag%0d waits%0d need=0 flag0 waits4", rd, seen, w);
      end
   endtask

   task automatic test_penable_idle();
      logic [31:0] rd; logic er; int w; bit lk; bit seen;
      seen = 0;
      @(posedge clk); #1;
      psel[0] = 1; penable[0] = 1; pwrite[0] = 0; paddr[0] = 12'h004;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); if (pready[0] || prdata[0] != 0) seen = 1;
      end
      @(posedge clk); #1; psel[0] = 0; penable[0] = 0;
      total++;
      if (seen) begin bad++; $display("FAIL penable_idle got=response need=none"); end
      xfer(0, 1'b0, 12'h004, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'hDEADBEEF || w != 1) begin
         bad++; $display("FAIL penable_idle_after got=%h waits%0d need=deadbeef waits1", rd, w);
      end
   endtask

`ifdef APB_REGBANK_PROT_EN
   task automatic test_prot();
      logic [31:0] rd; logic er; int w; bit lk;
      pprot[0] = 3'b000;
      xfer(0, 1'b1, 12'h014, 32'h1, 4'hF, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b1) begin bad++; $display("FAIL prot_wr got=%b need=1", er); end
      xfer(0, 1'b0, 12'h004, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL prot_rd got=%b/%h need=1/0", er, rd); end
      pprot[0] = 3'b001;
      xfer(0, 1'b0, 12'h014, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL prot_readback got=%b/%h need=0/0", er, rd); end
   endtask
`endif

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int w; bit lk;
      @(posedge clk); #1;
      psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 12'h00C; pwdata[2] = 32'h55; pstrb[2] = 4'hF;
      @(posedge clk); #1; penable[2] = 1;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (pready[2] !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b need=0", pready[2]); end
      #1 rst = 1'b1;
      #1;
      total++;
      if ({pready[2], pslverr[2], prdata[2]} !== 34'b0) begin
         bad++; $display("FAIL mid_rst_out got=%b/%b/%h need=0/0/0", pready[2], pslverr[2], prdata[2]);
      end
      @(posedge clk); #1; psel[2] = 0; penable[2] = 0;
      @(posedge clk); #1; rst = 1'b0;
      xfer(2, 1'b0, 12'h00C, 0, 4'h0, 0, rd, er, w, lk);
      total++;
      if (rd !== 32'h0 || w != 3) begin bad++; $display("FAIL mid_readback got=%h waits%0d need=0 waits3", rd, w); end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0;
         pwdata[d] = '0; pstrb[d] = '0; pprot[d] = 3'b001;
      end
      repeat (2) @(posedge clk);
      test_reset();
      test_basic();
      test_strobe();
      test_errors();
      test_wait();
      test_back_to_back();
      test_abort();
      test_penable_idle();
`ifdef APB_REGBANK_PROT_EN
      test_prot();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
